image_frame_streamer: RTL and testbench

- Downstream of the 32x32 dilation stage; consumes its 1024-bit processed image.
- On start, captures the frame, scans it row by row for the bounding box of set pixels, and computes a shift that centres the glyph.
- Streams the centred frame one pixel per handshake to the DNN input layer over valid/ready.
- Isolates the combinational image path from the network's serial pixel consumer.

---
 rtl/image_frame_streamer.sv | 157 +++++++++++++++
 tb/tb_image_frame_streamer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_frame_streamer.sv
// Captures a 32x32 binary frame, finds the bounding box of set pixels, and streams the
// glyph-centred frame one pixel per valid/ready handshake in raster order.
module image_frame_streamer #(
    parameter int unsigned PIXEL_W   = 8,
    parameter int unsigned ON_VALUE  = 255,
    parameter int unsigned CENTER_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1023:0]      image_in,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [PIXEL_W-1:0] pix_data,
    output logic [9:0]         pix_index,
    output logic               pix_last,
    output logic               busy,
    output logic               done,
    output logic               empty_image
);

    localparam logic [PIXEL_W-1:0] OnPix = PIXEL_W'(ON_VALUE);

    typedef enum logic [2:0] {StIdle, StScan, StCalc, StStream, StDone} state_e;

    state_e              state_q;
    logic [1023:0]       cap_q;
    logic [4:0]          row_q;
    logic [4:0]          top_q;
    logic [4:0]          bot_q;
    logic [31:0]         col_acc_q;
    logic signed [6:0]   dx_q;
    logic signed [6:0]   dy_q;

    logic [31:0]         row_bits;
    logic                row_or;
    logic [4:0]          left;
    logic [4:0]          right;
    logic                any_set;
    logic signed [7:0]   sum_x;
    logic signed [7:0]   sum_y;
    logic [9:0]          nxt_idx;
    logic signed [7:0]   src_r;
    logic signed [7:0]   src_c;
    logic                src_in;
    logic                nxt_bit;

    // Pixel p lives at cap_q[1023-p], and 1023-p == ~p for a 10-bit p.
    always_comb begin
        row_bits = '0;
        for (int c = 0; c < 32; c++) begin
            row_bits[c] = cap_q[~{row_q, 5'(c)}];
        end
        row_or = |row_bits;
    end

    always_comb begin
        left  = 5'd0;
        right = 5'd0;
        for (int c = 31; c >= 0; c--) begin
            if (col_acc_q[c]) left = 5'(c);
        end
        for (int c = 0; c < 32; c++) begin
            if (col_acc_q[c]) right = 5'(c);
        end
        any_set = |col_acc_q;
        sum_x   = 8'sd31 - $signed({3'b000, left}) - $signed({3'b000, right});
        sum_y   = 8'sd31 - $signed({3'b000, top_q}) - $signed({3'b000, bot_q});
    end

    // Source pixel for the beat that will be presented after the next accepting edge.
    always_comb begin
        nxt_idx = pix_valid ? (pix_index + 10'd1) : 10'd0;
        src_r   = $signed({3'b000, nxt_idx[9:5]}) - $signed({dy_q[6], dy_q});
        src_c   = $signed({3'b000, nxt_idx[4:0]}) - $signed({dx_q[6], dx_q});
        src_in  = (src_r[7:5] == 3'b000) && (src_c[7:5] == 3'b000);
        nxt_bit = src_in && cap_q[~{src_r[4:0], src_c[4:0]}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cap_q       <= '0;
            row_q       <= '0;
            top_q       <= '0;
            bot_q       <= '0;
            col_acc_q   <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            pix_index   <= '0;
            pix_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            empty_image <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        cap_q     <= image_in;
                        col_acc_q <= '0;
                        top_q     <= 5'd31;
                        bot_q     <= 5'd0;
                        row_q     <= 5'd0;
                        busy      <= 1'b1;
                        state_q   <= StScan;
                    end
                end
                StScan: begin
                    if (row_or) begin
                        if (row_q < top_q) top_q <= row_q;
                        bot_q <= row_q;
                    end
                    col_acc_q <= col_acc_q | row_bits;
                    row_q     <= row_q + 5'd1;
                    if (row_q == 5'd31) state_q <= StCalc;
                end
                StCalc: begin
                    empty_image <= ~any_set;
                    // Floor of a signed halving is just dropping the LSB.
                    if (any_set && (CENTER_EN != 0)) begin
                        dx_q <= sum_x[7:1];
                        dy_q <= sum_y[7:1];
                    end else begin
                        dx_q <= '0;
                        dy_q <= '0;
                    end
                    state_q <= StStream;
                end
                StStream: begin
                    if (!pix_valid || pix_ready) begin
                        if (pix_valid && pix_last) begin
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            done      <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            pix_valid <= 1'b1;
                            pix_index <= nxt_idx;
                            pix_data  <= nxt_bit ? OnPix : '0;
                            pix_last  <= (nxt_idx == 10'd1023);
                        end
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_image_frame_streamer.sv
// Scoreboard bench: a bench-side centring model fills expected beats at start; a monitor
// pops and compares them on every handshake, for a centring and a non-centring instance.
module tb_image_frame_streamer;

    typedef struct {
        int idx;
        int data;
        int last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1023:0] image_in;
    logic          pix_ready;
    logic          pix_valid, pix_last, busy, done, empty_image;
    logic [7:0]    pix_data;
    logic [9:0]    pix_index;
    logic          nc_valid, nc_last, nc_busy, nc_done, nc_empty;
    logic [7:0]    nc_data;
    logic [9:0]    nc_index;

    int    n_vec = 0;
    int    n_bad = 0;
    int    ready_mode = 0;
    beat_t q[$];
    int    q_nc[$];

    always #5 clk = ~clk;

    image_frame_streamer #(.PIXEL_W(8), .ON_VALUE(255), .CENTER_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .image_in(image_in),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_index(pix_index), .pix_last(pix_last), .busy(busy), .done(done),
        .empty_image(empty_image)
    );

    image_frame_streamer #(.PIXEL_W(8), .ON_VALUE(255), .CENTER_EN(0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .start(start), .image_in(image_in),
        .pix_valid(nc_valid), .pix_ready(pix_ready), .pix_data(nc_data),
        .pix_index(nc_index), .pix_last(nc_last), .busy(nc_busy), .done(nc_done),
        .empty_image(nc_empty)
    );

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void shift_of(input logic [1023:0] f, input bit en, output int dx,
                                     output int dy, output bit emp);
        int top = 32, bot = -1, left = 32, right = -1;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                if (f[1023 - (r * 32 + c)]) begin
                    if (r < top) top = r;
                    if (r > bot) bot = r;
                    if (c < left) left = c;
                    if (c > right) right = c;
                end
            end
        end
        emp = (bot < 0);
        if (emp || !en) begin
            dx = 0;
            dy = 0;
        end else begin
            dx = (31 - left - right) >>> 1;
            dy = (31 - top - bot) >>> 1;
        end
    endfunction

    function automatic int exp_pix(input logic [1023:0] f, input int dx, input int dy,
                                   input int idx);
        int sr = idx / 32 - dy;
        int sc = idx % 32 - dx;
        if (sr < 0 || sr > 31 || sc < 0 || sc > 31) return 0;
        return f[1023 - (sr * 32 + sc)] ? 255 : 0;
    endfunction

    function automatic logic [1023:0] set_pix(input logic [1023:0] f, input int r, input int c);
        logic [1023:0] g = f;
        g[1023 - (r * 32 + c)] = 1'b1;
        return g;
    endfunction

    task automatic push_frame(input logic [1023:0] f);
        int dx, dy, dx0, dy0;
        bit emp, emp0;
        beat_t b;
        shift_of(f, 1'b1, dx, dy, emp);
        shift_of(f, 1'b0, dx0, dy0, emp0);
        for (int i = 0; i < 1024; i++) begin
            b.idx  = i;
            b.data = exp_pix(f, dx, dy, i);
            b.last = (i == 1023) ? 1 : 0;
            q.push_back(b);
            q_nc.push_back(exp_pix(f, dx0, dy0, i));
        end
    endtask

    // pix_ready pattern: 0 = always high, 1 = 1,0,0,1 repeating, 2 = random.
    initial begin : ready_gen
        int cyc = 0;
        pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ready_mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        bit   prev_stall = 0;
        int   prev_data = 0, prev_idx = 0;
        bit   has;
        beat_t e;
        int   e_nc;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check_eq("stall_data", pix_data, prev_data);
                    check_eq("stall_index", pix_index, prev_idx);
                    check_eq("stall_valid", pix_valid, 1);
                end
                if (pix_valid && pix_ready) begin
                    has = (q.size() > 0) && (q_nc.size() > 0);
                    check_eq("beat_expected", has, 1);
                    if (has) begin
                        e    = q.pop_front();
                        e_nc = q_nc.pop_front();
                        check_eq("pix_index", pix_index, e.idx);
                        check_eq("pix_data", pix_data, e.data);
                        check_eq("pix_last", pix_last, e.last);
                        check_eq("nc_valid", nc_valid, 1);
                        check_eq("nc_index", nc_index, e.idx);
                        check_eq("nc_data", nc_data, e_nc);
                    end
                end
                prev_stall = pix_valid && !pix_ready;
                prev_data  = pix_data;
                prev_idx   = pix_index;
            end
        end
    end

    task automatic run_frame(input logic [1023:0] f, input int rmode, input bit disturb);
        int dx, dy, dx0, dy0, t;
        bit emp, emp0;
        shift_of(f, 1'b1, dx, dy, emp);
        shift_of(f, 1'b0, dx0, dy0, emp0);
        push_frame(f);
        ready_mode = rmode;
        @(negedge clk);
        image_in = f;
        start    = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        if (disturb) image_in = ~f;
        check_eq("busy_after_start", busy, 1);
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk);
            #2;
            if (k == 33) check_eq("valid_before_n34", pix_valid, 0);
            if (k == 34) check_eq("valid_at_n34", pix_valid, 1);
        end
        t = 0;
        while (!done && t < 5000) begin
            @(posedge clk);
            #2;
            t++;
            if (disturb && t == 50) start = 1'b1;
            if (disturb && t == 53) begin
                start    = 1'b0;
                image_in = {$urandom, $urandom, $urandom, $urandom, f[895:0]};
            end
        end
        check_eq("done_pulse", done, 1);
        check_eq("busy_in_done", busy, 1);
        check_eq("nc_done", nc_done, 1);
        check_eq("empty_image", empty_image, emp);
        check_eq("nc_empty_image", nc_empty, emp0);
        @(posedge clk);
        #2;
        check_eq("done_one_cycle", done, 0);
        check_eq("busy_idle", busy, 0);
        check_eq("beats_missing", q.size(), 0);
        check_eq("nc_beats_missing", q_nc.size(), 0);
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [1023:0] f;
        int t;
        rst_n    = 1'b0;
        start    = 1'b0;
        image_in = '0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_valid", pix_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_empty", empty_image, 0);
        check_eq("rst_data", pix_data, 0);
        check_eq("rst_index", pix_index, 0);
        check_eq("rst_last", pix_last, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(set_pix('0, 0, 0), 0, 1'b0);
        run_frame(set_pix('0, 31, 31), 0, 1'b0);
        run_frame(set_pix('0, 0, 31), 0, 1'b0);
        run_frame('0, 0, 1'b0);

        f = '0;
        for (int r = 2; r <= 4; r++)
            for (int c = 2; c <= 4; c++) f = set_pix(f, r, c);
        run_frame(f, 1, 1'b0);

        f = '0;
        for (int r = 5; r <= 20; r++)
            for (int c = 8; c <= 10; c++) f = set_pix(f, r, c);
        f = set_pix(f, 3, 29);
        run_frame(f, 2, 1'b1);

        run_frame('1, 0, 1'b0);

        // Reset in the middle of a stream, then a fresh frame.
        f = set_pix(set_pix('0, 7, 0), 9, 4);
        push_frame(f);
        ready_mode = 0;
        @(negedge clk);
        image_in = f;
        start    = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        t = 0;
        while (!(pix_valid && pix_index == 10'd300) && t < 2000) begin
            @(posedge clk);
            #2;
            t++;
        end
        check_eq("reached_index_300", pix_index, 300);
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", pix_valid, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_empty", empty_image, 0);
        q.delete();
        q_nc.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(set_pix('0, 10, 3), 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
